zimbo_uart_tx: RTL and testbench

ZIMBO_UART_TX -- requirements
Module: zimbo_uart_tx

---
 rtl/zimbo_uart_tx.sv | 185 ++++++++++++++++++
 tb/tb_zimbo_uart_tx.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zimbo_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small transmit FIFO.
// DATA register pushes a byte; STATUS reports FIFO/line state and a sticky overflow flag.
module zimbo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addrm,
    input  logic [15:0] wmdata,
    input  logic        memwr_en,
    output logic        io_sel,
    output logic [15:0] io_rdata,
    output logic        txd,
    output logic        tx_busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BaudReload = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] FullCount = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] StatusAddr = BASE_ADDR + 16'd1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          sel_q, sts_q;

    logic          wr_data, wr_status, push, pop, full, empty;
    logic [15:0]   status;
    logic          unused_wdata_hi;

    assign unused_wdata_hi = ^wmdata[15:8];

    assign wr_data   = memwr_en && (addrm == BASE_ADDR);
    assign wr_status = memwr_en && (addrm == StatusAddr);
    assign full      = (count_q == FullCount);
    assign empty     = (count_q == '0);
    // A full FIFO still takes a write when the shifter pops on the same edge.
    assign push      = wr_data && (!full || pop);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (wr_data && !push) begin
            ovf_d = 1'b1;
        end else if (wr_status && wmdata[0]) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wmdata[7:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            sel_q    <= 1'b0;
            sts_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
            sel_q   <= (addrm == BASE_ADDR) || (addrm == StatusAddr);
            sts_q   <= (addrm == StatusAddr);
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                txd_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = BaudReload;
                    state_d = StStart;
                    txd_d   = 1'b0;
                end
            end
            StStart: begin
                if (baud_q == '0) begin
                    baud_d  = BaudReload;
                    bit_d   = '0;
                    state_d = StData;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            StData: begin
                if (baud_q == '0) begin
                    baud_d = BaudReload;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            StStop: begin
                txd_d = 1'b1;
                if (baud_q == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        baud_d  = BaudReload;
                        state_d = StStart;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign tx_busy  = (state_q != StIdle) || !empty;
    assign status   = {11'b0, ovf_q, full, empty, tx_busy, ~full};
    assign io_sel   = sel_q;
    assign io_rdata = (sel_q && sts_q) ? status : 16'h0000;
    assign txd      = txd_q;

endmodule

// File: tb/tb_zimbo_uart_tx.sv
// Bench for zimbo_uart_tx: scoreboard of expected bytes checked by a line monitor,
// plus per-scenario register and waveform checks.
module tb_zimbo_uart_tx;

    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addrm = '0;
    logic [15:0] wmdata = '0;
    logic        memwr_en = 1'b0;
    logic        io_sel;
    logic [15:0] io_rdata;
    logic        txd;
    logic        tx_busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         starts[$];
    logic       mon_en = 1'b0;
    logic       m_active = 1'b0;

    zimbo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR   (16'hFF00),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .addrm   (addrm),
        .wmdata  (wmdata),
        .memwr_en(memwr_en),
        .io_sel  (io_sel),
        .io_rdata(io_rdata),
        .txd     (txd),
        .tx_busy (tx_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [15:0] sts(input logic ovf, input logic full, input logic empty,
                                        input logic busy);
        return {11'b0, ovf, full, empty, busy, ~full};
    endfunction

    // Line monitor: decodes frames at mid-bit and compares against the scoreboard.
    initial begin
        int         cnt;
        logic [7:0] b;
        logic [7:0] e;
        cnt = 0;
        b = '0;
        forever begin
            @(negedge clock);
            if (reset || !mon_en) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (txd === 1'b0) begin
                    m_active = 1'b1;
                    cnt = 0;
                    b = '0;
                    starts.push_back(cyc);
                end
            end else begin
                cnt++;
                if (cnt == 2) begin
                    checks++;
                    if (txd !== 1'b0) begin
                        errors++;
                        $display("FAIL start_bit: txd=%b expected 0", txd);
                    end
                end
                if (cnt >= 6 && cnt <= 34 && ((cnt - 6) % 4) == 0) b[(cnt - 6) / 4] = txd;
                if (cnt == 38) begin
                    checks++;
                    if (txd !== 1'b1) begin
                        errors++;
                        $display("FAIL stop_bit: txd=%b expected 1", txd);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_frame: got %h expected none", b);
                    end else begin
                        e = exp_q.pop_front();
                        if (b !== e) begin
                            errors++;
                            $display("FAIL frame_byte: got %h expected %h", b, e);
                        end
                    end
                end
                if (cnt == 39) m_active = 1'b0;
            end
        end
    end

    // All bus tasks start and end at a falling edge.
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addrm = a;
        wmdata = d;
        memwr_en = 1'b1;
        @(negedge clock);
    endtask

    task automatic bus_idle();
        memwr_en = 1'b0;
        addrm = 16'h0000;
        wmdata = 16'h0000;
    endtask

    task automatic rd(input logic [15:0] a, output logic sel, output logic [15:0] d);
        memwr_en = 1'b0;
        addrm = a;
        @(negedge clock);
        sel = io_sel;
        d = io_rdata;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clock);
            done = (exp_q.size() == 0) && !m_active && (tx_busy === 1'b0);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: pending=%0d busy=%b expected drained", name,
                     exp_q.size(), tx_busy);
        end
    endtask

    task automatic check_spacing(input string name, input int n);
        checks++;
        if (starts.size() != n) begin
            errors++;
            $display("FAIL %s_frames: got %0d expected %0d", name, starts.size(), n);
        end
        for (int i = 1; i < starts.size(); i++) begin
            checks++;
            if (starts[i] - starts[i-1] != FRAME) begin
                errors++;
                $display("FAIL %s_gap: got %0d expected %0d", name, starts[i] - starts[i-1],
                         FRAME);
            end
        end
    endtask

    task automatic check_status(input string name, input logic [15:0] exp);
        logic        s;
        logic [15:0] d;
        rd(16'hFF01, s, d);
        checks++;
        if (s !== 1'b1 || d !== exp) begin
            errors++;
            $display("FAIL %s: io_sel=%b io_rdata=%h expected 1/%h", name, s, d, exp);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if (txd !== 1'b1 || tx_busy !== 1'b0 || io_sel !== 1'b0 || io_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: txd=%b busy=%b sel=%b rdata=%h expected 1/0/0/0000",
                     txd, tx_busy, io_sel, io_rdata);
        end
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_read_path();
        logic        s;
        logic [15:0] d;
        check_status("read_status_reset", sts(1'b0, 1'b0, 1'b1, 1'b0));
        rd(16'h0010, s, d);
        checks++;
        if (s !== 1'b0 || d !== 16'h0000) begin
            errors++;
            $display("FAIL read_other: io_sel=%b io_rdata=%h expected 0/0000", s, d);
        end
        rd(16'hFF00, s, d);
        checks++;
        if (s !== 1'b1 || d !== 16'h0000) begin
            errors++;
            $display("FAIL read_data: io_sel=%b io_rdata=%h expected 1/0000", s, d);
        end
        bus_idle();
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        logic       et;
        logic       eb;
        b = 8'h55;
        starts.delete();
        exp_q.push_back(b);
        wr(16'hFF00, 16'h1255);
        bus_idle();
        for (int k = 0; k <= 41; k++) begin
            if (k > 0) @(negedge clock);
            if (k >= 1 && k <= 4) et = 1'b0;
            else if (k >= 5 && k <= 36) et = b[(k - 5) / 4];
            else et = 1'b1;
            eb = (k <= 40);
            checks++;
            if (txd !== et || tx_busy !== eb) begin
                errors++;
                $display("FAIL frame_wave k=%0d: txd=%b busy=%b expected %b/%b", k, txd,
                         tx_busy, et, eb);
            end
        end
        wait_idle("single");
        check_spacing("single", 1);
    endtask

    task automatic test_back_to_back_overflow();
        logic [15:0] words[6];
        words = '{16'hAB01, 16'h0082, 16'hFFC3, 16'h1E44, 16'h7705, 16'h00EE};
        starts.delete();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back(words[i][7:0]);
            wr(16'hFF00, words[i]);
        end
        bus_idle();
        check_status("ovf_set", sts(1'b1, 1'b1, 1'b0, 1'b1));
        wr(16'hFF01, 16'hFFFE);
        check_status("ovf_no_clear", sts(1'b1, 1'b1, 1'b0, 1'b1));
        wr(16'hFF01, 16'h0001);
        check_status("ovf_clear", sts(1'b0, 1'b1, 1'b0, 1'b1));
        wr(16'hFF02, 16'h0099);
        check_status("other_addr_write", sts(1'b0, 1'b1, 1'b0, 1'b1));
        bus_idle();
        wait_idle("b2b");
        check_spacing("b2b", 5);
    endtask

    task automatic test_push_on_pop();
        logic [7:0] bytes[6];
        bytes = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'hF6};
        starts.delete();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(bytes[i]);
            wr(16'hFF00, {8'h00, bytes[i]});
        end
        bus_idle();
        repeat (35) @(negedge clock);
        check_status("full_before_pop", sts(1'b0, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(bytes[5]);
        wr(16'hFF00, {8'h00, bytes[5]});
        check_status("push_on_pop", sts(1'b0, 1'b1, 1'b0, 1'b1));
        bus_idle();
        wait_idle("pushpop");
        check_spacing("pushpop", 6);
    endtask

    task automatic test_reset_midframe();
        int lows;
        wr(16'hFF00, 16'h00C9);
        wr(16'hFF00, 16'h0033);
        bus_idle();
        repeat (16) @(negedge clock);
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (txd !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: txd=%b busy=%b expected 1/0", txd, tx_busy);
        end
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        mon_en = 1'b1;
        check_status("status_after_reset", sts(1'b0, 1'b0, 1'b1, 1'b0));
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (txd !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        checks++;
        if (lows != 0) begin
            errors++;
            $display("FAIL residual_frame: active cycles=%0d expected 0", lows);
        end
        // Write lands on the very first rising edge after release.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        starts.delete();
        exp_q.push_back(8'h3C);
        wr(16'hFF00, 16'h003C);
        bus_idle();
        checks++;
        if (tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL first_edge_write: busy=%b expected 1", tx_busy);
        end
        wait_idle("post_reset");
        check_spacing("post_reset", 1);
    endtask

    initial begin
        test_reset();
        test_read_path();
        test_single_frame();
        test_back_to_back_overflow();
        test_push_on_pop();
        test_reset_midframe();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
